// File: rtl/reflex_pkg.sv
// Shared definitions for the reaction-timer game round and its display/score consumers.
package reflex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GO   = 2'd2
   } state_t;

   localparam int RND_W                = 12;
   localparam int RES_W                = 14;
   localparam int TICK_DIV_DEFAULT     = 100000;
   localparam int MIN_DELAY_MS_DEFAULT = 1000;
   localparam int TIMEOUT_MS_DEFAULT   = 9999;

endpackage

// File: rtl/reaction_timer_ms_tick_gen.sv
// Millisecond strobe: one-cycle tick every TICK_DIV clocks while en is high.
// Held at its reload value while en is low, so the first ms after enabling is full length.
module ms_tick_gen
   import reflex_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;

   always_comb begin
      div_d = div_q;
      if (!en || (div_q == '0)) begin
         div_d = DIV_LOAD;
      end else begin
         div_d = div_q - 1'b1;
      end
   end

   assign tick = en && (div_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= DIV_LOAD;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-timer round controller: random wait, GO phase, reaction time in ms.
// Optional best-score tracking is built only when BEST_SCORE_EN is defined.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no round running; start latches rnd and begins the wait
//   ST_WAIT | random delay running; a press here is a false start
//   ST_GO   | GO LED lit; a press captures the reaction time, else timeout
module reaction_timer
   import reflex_pkg::*;
#(
   parameter int TICK_DIV     = TICK_DIV_DEFAULT,
   parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEFAULT,
   parameter int TIMEOUT_MS   = TIMEOUT_MS_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RND_W-1:0] rnd,
   input  logic             start,
   input  logic             btn,
   output logic             go_led,
   output logic             busy,
   output logic [RES_W-1:0] result_ms,
   output logic             result_valid,
   output logic             false_start,
   output logic             timeout,
   output logic [RES_W-1:0] best_ms
);

   localparam logic [RES_W:0]   MIN_DELAY  = (RES_W + 1)'(MIN_DELAY_MS);
   localparam logic [RES_W-1:0] TIMEOUT_C  = RES_W'(TIMEOUT_MS);

   state_t           state_q, state_d;
   logic [RES_W-1:0] ms_cnt_q, ms_cnt_d;
   logic [RES_W:0]   delay_q, delay_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             false_start_q, false_start_d;
   logic             timeout_q, timeout_d;
   logic             go_led_q, go_led_d;
   logic             busy_q, busy_d;
   logic             btn_q;
   logic             press;
   logic             tick;

   ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (busy_q),
      .tick (tick)
   );

   assign press = btn & ~btn_q;

   always_comb begin
      state_d        = state_q;
      ms_cnt_d       = ms_cnt_q;
      delay_d        = delay_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      false_start_d  = false_start_q;
      timeout_d      = timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d       = ST_WAIT;
               delay_d       = MIN_DELAY + (RES_W + 1)'(rnd);
               ms_cnt_d      = '0;
               false_start_d = 1'b0;
               timeout_d     = 1'b0;
            end
         end
         ST_WAIT: begin
            if (press) begin
               state_d       = ST_IDLE;
               false_start_d = 1'b1;
            end else if (tick) begin
               if ({1'b0, ms_cnt_q} == (delay_q - 1'b1)) begin
                  state_d  = ST_GO;
                  ms_cnt_d = '0;
               end else begin
                  ms_cnt_d = ms_cnt_q + 1'b1;
               end
            end
         end
         ST_GO: begin
            // A press beats a same-cycle tick so the count shown is what the player saw.
            if (press) begin
               state_d        = ST_IDLE;
               result_d       = ms_cnt_q;
               result_valid_d = 1'b1;
            end else if (tick) begin
               if (ms_cnt_q == TIMEOUT_C) begin
                  state_d   = ST_IDLE;
                  timeout_d = 1'b1;
               end else begin
                  ms_cnt_d = ms_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      go_led_d = (state_d == ST_GO);
      busy_d   = (state_d == ST_WAIT) || (state_d == ST_GO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         ms_cnt_q       <= '0;
         delay_q        <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         false_start_q  <= 1'b0;
         timeout_q      <= 1'b0;
         go_led_q       <= 1'b0;
         busy_q         <= 1'b0;
         btn_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         ms_cnt_q       <= ms_cnt_d;
         delay_q        <= delay_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         false_start_q  <= false_start_d;
         timeout_q      <= timeout_d;
         go_led_q       <= go_led_d;
         busy_q         <= busy_d;
         btn_q          <= btn;
      end
   end

`ifdef BEST_SCORE_EN
   logic [RES_W-1:0] best_q, best_d;

   always_comb begin
      best_d = best_q;
      if (result_valid_d && (result_d < best_q)) begin
         best_d = result_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         best_q <= '1;
      end else begin
         best_q <= best_d;
      end
   end

   assign best_ms = best_q;
`else
   assign best_ms = '1;
`endif

   assign go_led       = go_led_q;
   assign busy         = busy_q;
   assign result_ms    = result_q;
   assign result_valid = result_valid_q;
   assign false_start  = false_start_q;
   assign timeout      = timeout_q;

endmodule
